// File: rtl/vector_sweeper_pkg.sv
// Shared types and sizing helpers for the exhaustive vector sweeper.
package sweep_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of input combinations walked for an n-input circuit.
    function automatic int nvec(input int n);
        return 1 << n;
    endfunction

    // Error counter width: one bit wider than the input count, so the
    // count can reach nvec(n) without wrapping.
    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/vector_sweeper_if.sv
// Stimulus / result bundle between the sweeper, the circuit under test and
// whoever launches the sweep. The sweeper connects through the slave modport.
interface vector_sweeper_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
);
    logic               start;
    logic               halt_on_fail;
    logic [N_OUT-1:0]   cmp_mask;
    logic [N_IN-1:0]    dut_in;
    logic [N_OUT-1:0]   dut_out;
    logic [N_OUT-1:0]   exp_out;
    logic               busy;
    logic               done;
    logic               pass;
    logic [N_IN:0]      err_count;
    logic [N_IN-1:0]    first_fail_vec;
    logic               first_fail_valid;

    modport slave (
        input  start, halt_on_fail, cmp_mask, dut_out, exp_out,
        output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

    modport master (
        output start, halt_on_fail, cmp_mask, dut_out, exp_out,
        input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/vector_sweeper_hold_counter.sv
// Mod-HOLD_CYC counter; last marks the final hold cycle of a vector, which is
// the cycle on which the circuit outputs are sampled.
module hold_counter #(
    parameter int HOLD_CYC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [W-1:0] CNT_LAST = W'(HOLD_CYC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap after the last hold cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/vector_sweeper.sv
// Exhaustive stimulus engine: drives every input combination for HOLD_CYC
// clocks, compares the circuit outputs against the expected value on the last
// hold cycle under a mask, and reports error count, first failure and pass.
module vector_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int N_OUT    = 2,
    parameter int HOLD_CYC = 10
) (
    input  logic            clk,
    input  logic            rst,
    vector_sweeper_if.slave sw
);
    localparam int CW = cnt_w(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(nvec(N_IN) - 1);

    state_t             state_q, state_d;
    logic [N_IN-1:0]    dut_in_q, dut_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [CW-1:0]      err_q, err_d;
    logic [N_IN-1:0]    ff_vec_q, ff_vec_d;
    logic               ff_valid_q, ff_valid_d;
    logic [N_OUT-1:0]   mask_q, mask_d;
    logic               halt_q, halt_d;
    // High for the single cycle between the start edge and the first hold
    // cycle of vector 0, so every vector gets exactly HOLD_CYC driven cycles
    // measured from the edge after start is taken.
    logic               launch_q, launch_d;

    logic               hold_clr;
    logic               hold_en;
    logic               hold_last;
    logic [N_OUT-1:0]   miss_bits;
    logic               mismatch;

    hold_counter #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clr  (hold_clr),
        .en   (hold_en),
        .last (hold_last)
    );

    // Per-output compare under the mask latched at start.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_cmp
            assign miss_bits[gi] = (sw.dut_out[gi] ^ sw.exp_out[gi]) & mask_q[gi];
        end
    endgenerate

    assign mismatch = |miss_bits;

    // Next-state and result update for the sweep controller.
    always_comb begin
        state_d    = state_q;
        dut_in_d   = dut_in_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        mask_d     = mask_q;
        halt_d     = halt_q;
        launch_d   = 1'b0;
        hold_clr   = 1'b0;
        hold_en    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (sw.start) begin
                    state_d    = ST_DRIVE;
                    dut_in_d   = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    ff_vec_d   = '0;
                    ff_valid_d = 1'b0;
                    mask_d     = sw.cmp_mask;
                    halt_d     = sw.halt_on_fail;
                    launch_d   = 1'b1;
                    hold_clr   = 1'b1;
                end
            end

            ST_DRIVE: begin
                if (launch_q) begin
                    hold_clr = 1'b1;
                end else begin
                    hold_en = 1'b1;
                    if (hold_last) begin
                        if (mismatch) begin
                            err_d = err_q + 1'b1;
                            if (!ff_valid_q) begin
                                ff_vec_d   = dut_in_q;
                                ff_valid_d = 1'b1;
                            end
                        end
                        if ((dut_in_q == LAST_VEC) || (mismatch && halt_q)) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                        end else begin
                            dut_in_d = dut_in_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and result registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            mask_q     <= '0;
            halt_q     <= 1'b0;
            launch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dut_in_q   <= dut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            mask_q     <= mask_d;
            halt_q     <= halt_d;
            launch_q   <= launch_d;
        end
    end

    assign sw.dut_in           = dut_in_q;
    assign sw.busy             = busy_q;
    assign sw.done             = done_q;
    assign sw.pass             = pass_q;
    assign sw.err_count        = err_q;
    assign sw.first_fail_vec   = ff_vec_q;
    assign sw.first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_vector_sweeper.sv
// Bench for vector_sweeper: 3-input circuit D=A&B, E=B|C, hold of 4 clocks.
// exp_out is the same truth table with per-vector bit flips from flip_tbl.
module tb_vector_sweeper;
    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int HOLD  = 4;
    localparam int NV    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2*NV-1:0] flip_tbl = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_sweeper_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    vector_sweeper #(
        .N_IN     (N_IN),
        .N_OUT    (N_OUT),
        .HOLD_CYC (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (bus.slave)
    );

    // Circuit under test and its expected-value lookup.
    function automatic logic [1:0] golden(input logic [2:0] v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return {b | c, a & b};
    endfunction

    assign bus.dut_out = golden(bus.dut_in);
    assign bus.exp_out = golden(bus.dut_in) ^ flip_tbl[bus.dut_in*2 +: 2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [13:0] all_outs();
        return {bus.dut_in, bus.busy, bus.done, bus.pass, bus.err_count,
                bus.first_fail_vec, bus.first_fail_valid};
    endfunction

    // Reference: walk the truth table, count masked mismatches, stop on halt.
    task automatic ref_model(input logic [15:0] flips, input logic [1:0] mask, input logic halt,
                             output int vlast, output int err, output int first,
                             output int valid, output int done_edge);
        err = 0; first = 0; valid = 0; vlast = NV - 1;
        for (int v = 0; v < NV; v++) begin
            logic [1:0] f;
            f = flips[v*2 +: 2];
            if ((f & mask) != 2'b00) begin
                err++;
                if (valid == 0) begin
                    first = v; valid = 1;
                end
                if (halt) begin
                    vlast = v;
                    break;
                end
            end
        end
        done_edge = 1 + (vlast + 1) * HOLD;
    endtask

    typedef struct {
        logic [15:0] flips;
        logic [1:0]  mask;
        logic        halt;
        int          poke;
        int          e_err;
        int          e_first;
        int          e_valid;
        int          e_pass;
        int          e_done;
        int          e_last;
    } vec_t;

    // One sweep: start, optional stray start at offset poke, then check
    // trace, completion edge and results against the given expectations.
    task automatic run_sweep(input string nm, input logic [15:0] flips, input logic [1:0] mask,
                             input logic halt, input int poke, input int e_err, input int e_first,
                             input int e_valid, input int e_pass, input int e_done, input int e_last);
        int j;
        int done_at;
        int trace_err;
        trace_err = 0;
        done_at = -1;
        @(negedge clk);
        flip_tbl = flips;
        bus.cmp_mask = mask;
        bus.halt_on_fail = halt;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = (poke == 1);
        bus.cmp_mask = ~mask;
        bus.halt_on_fail = ~halt;
        chk({nm, ".launch"},
            {28'd0, bus.dut_in == 3'd0, bus.busy, bus.done, bus.err_count == 4'd0 && !bus.first_fail_valid},
            32'b1101);
        for (j = 1; j <= 200; j++) begin
            @(posedge clk); #1;
            bus.start = (j + 1 == poke);
            if (bus.done) begin
                done_at = j;
                break;
            end
            if (trace_err == 0 && (bus.dut_in !== 3'((j - 1) / HOLD) || bus.busy !== 1'b1)) begin
                trace_err = 1;
                $display("FAIL %s.trace: edge %0d dut_in=%0d busy=%0b expected dut_in=%0d busy=1",
                         nm, j, bus.dut_in, bus.busy, (j - 1) / HOLD);
            end
        end
        bus.start = 1'b0;
        chk({nm, ".trace"}, trace_err, 0);
        chk({nm, ".done_edge"}, done_at, e_done);
        chk({nm, ".busy"}, bus.busy, 0);
        chk({nm, ".dut_in"}, bus.dut_in, e_last);
        chk({nm, ".err_count"}, bus.err_count, e_err);
        chk({nm, ".ff_vec"}, bus.first_fail_vec, e_first);
        chk({nm, ".ff_valid"}, bus.first_fail_valid, e_valid);
        chk({nm, ".pass"}, bus.pass, e_pass);
        // Results must hold in DONE while start stays low.
        repeat (3) @(posedge clk);
        #1;
        chk({nm, ".hold"}, {bus.done, bus.err_count}, {1'b1, 4'(e_err)});
    endtask

    vec_t tbl[6];

    initial begin
        bus.start = 1'b0;
        bus.halt_on_fail = 1'b0;
        bus.cmp_mask = 2'b00;

        tbl[0] = '{16'h0000, 2'b11, 1'b0, 0,  0, 0, 0, 1, 33, 7};
        tbl[1] = '{16'h0400, 2'b11, 1'b0, 10, 1, 5, 1, 0, 33, 7};
        tbl[2] = '{16'h0400, 2'b10, 1'b0, 0,  0, 0, 0, 1, 33, 7};
        tbl[3] = '{16'h1010, 2'b11, 1'b1, 0,  1, 2, 1, 0, 13, 2};
        tbl[4] = '{16'hFFFF, 2'b00, 1'b1, 5,  0, 0, 0, 1, 33, 7};
        tbl[5] = '{16'hC003, 2'b11, 1'b0, 0,  2, 0, 1, 0, 33, 7};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", all_outs(), 0);

        // Table-driven sweeps; tbl[1] also carries a start pulse at edge 10
        // and tbl[3] -> tbl[4] restarts from a failing DONE.
        for (int i = 0; i < 6; i++) begin
            run_sweep($sformatf("tbl%0d", i), tbl[i].flips, tbl[i].mask, tbl[i].halt, tbl[i].poke,
                      tbl[i].e_err, tbl[i].e_first, tbl[i].e_valid, tbl[i].e_pass,
                      tbl[i].e_done, tbl[i].e_last);
        end

        // Reset mid-sweep while dut_in=4, mid-hold; partial failure discarded.
        begin
            int waited;
            waited = 0;
            @(negedge clk);
            flip_tbl = 16'h0004;
            bus.cmp_mask = 2'b11;
            bus.halt_on_fail = 1'b0;
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            while (bus.dut_in != 3'd4 && waited < 100) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("rst_reach_vec4", {31'd0, waited < 100}, 1);
            chk("rst_pre_err", bus.err_count, 1);
            @(posedge clk); #1;
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_mid_outs", all_outs(), 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("rst_stays_idle", all_outs(), 0);
            run_sweep("after_rst", 16'h0000, 2'b11, 1'b0, 0, 0, 0, 0, 1, 33, 7);
        end

        // Randomized sweeps against the reference model.
        for (int r = 0; r < 16; r++) begin
            logic [15:0] fl;
            logic [1:0]  mk;
            logic        ht;
            int vl, er, fi, va, de, pk;
            fl = 16'($urandom) & 16'($urandom) & 16'($urandom);
            mk = 2'($urandom);
            ht = 1'($urandom);
            ref_model(fl, mk, ht, vl, er, fi, va, de);
            pk = (r % 3 == 0) ? 0 : $urandom_range(1, de);
            run_sweep($sformatf("rnd%0d", r), fl, mk, ht, pk, er, fi, va, (er == 0) ? 1 : 0, de, vl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_sweeper.md
Name: vector_sweeper

Overview:
- Parametrised, self-checking exhaustive stimulus engine for small combinational circuits under test.
- Walks every input combination 0..2^N_IN-1 and holds each for HOLD_CYC clocks.
- Samples the circuit's outputs at the end of each hold and compares them, under a mask, against an externally supplied expected value.
- Reports the error count, the first failing vector and pass/fail. Sits beside the circuit under test in bench and on-board test harnesses, so a single instance drives and checks the whole truth table.

Parameters:
- N_IN, 3, number of circuit inputs; vector count NVEC = 2^N_IN.
- N_OUT, 2, number of circuit outputs compared.
- HOLD_CYC, 10, clocks each vector is held; legal range >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled in IDLE or DONE only.
- halt_on_fail  in  1  stop at the first mismatch; sampled on the start cycle.
- cmp_mask  in  N_OUT  1 = output bit compared; sampled on the start cycle.
- dut_in  out  N_IN  stimulus to the circuit under test (registered).
- dut_out  in  N_OUT  outputs of the circuit under test.
- exp_out  in  N_OUT  expected outputs for the current dut_in, from a combinational lookup outside this block.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until next start or rst.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  N_IN+1  mismatching vectors counted; cannot overflow, so no saturation logic.
- first_fail_vec  out  N_IN  dut_in value of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured value.

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge.
- Reset values: every output is 0; state IDLE; latched mask and halt are 0.
- Reset asserted mid-sweep: next edge returns to IDLE with all outputs 0; no partial results are kept.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1: go to DRIVE.
  - On that transition: dut_in=0, hold_cnt=0, busy=1, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0; latch cmp_mask and halt_on_fail.
- DRIVE:
  - hold_cnt increments each clock.
  - On the cycle with hold_cnt == HOLD_CYC-1 (the last hold cycle), compute mismatch = |((dut_out ^ exp_out) & mask).
  - On mismatch, err_count increments at that edge. If first_fail_valid=0, capture first_fail_vec=dut_in and set first_fail_valid=1.
  - Then: if dut_in == NVEC-1, or (mismatch and halt latched), go to DONE. dut_in stays at its last value.
  - Otherwise dut_in increments and hold_cnt returns to 0.
- DONE: busy=0, done=1, pass=(err_count==0), with the updated count included. start=1 restarts exactly as from IDLE.
- Latency:
  - Start sampled at edge k gives dut_in=0 from edge k+1.
  - Vector v is driven during cycles k+1+v*HOLD_CYC .. k+(v+1)*HOLD_CYC.
  - A full sweep asserts done at edge k+1+NVEC*HOLD_CYC.
- start while busy: ignored. Mask/halt changes while busy: no effect.
- Mask all zero: every vector passes.
- The sample point is the last hold cycle, so the circuit under test gets HOLD_CYC-1 clocks to settle.

Decomposition:
- Package sweep_pkg:
  - state typedef (IDLE, DRIVE, DONE).
  - Helper function for NVEC and the count width N_IN+1.
- Sub-module hold_counter:
  - Parameter HOLD_CYC, ports clk, rst, clr, en, last.
  - Mod-HOLD_CYC counter whose last flag marks the sample cycle.
- Remaining top-level logic: FSM, vector register, compare and result registers.

Test Plan:
- N_IN=3, HOLD_CYC=4, dut_out driven from a model with D=A&B, E=B|C, exp_out from the same model; start at edge 0 -> dut_in steps 0..7, 4 cycles each; done=1 at edge 33; pass=1; err_count=0; first_fail_valid=0.
- Same setup, but the exp_out model flips bit0 for vector 5 only -> err_count=1, first_fail_vec=5, first_fail_valid=1, pass=0, done at edge 33.
- Same mismatch with cmp_mask=2'b10 -> pass=1, err_count=0.
- halt_on_fail=1, mismatches at vectors 2 and 6 -> done at edge 13, dut_in=2, err_count=1, first_fail_vec=2, pass=0.
- rst pulsed for one cycle while dut_in=4, mid-hold -> next edge: all outputs 0, state IDLE; a later start sweeps again from dut_in=0 with a clean count.
- start pulsed at edge 10 during a sweep -> ignored, sweep timing unchanged. start in DONE after a failing run -> err_count and first_fail_valid clear on the restart edge; the new sweep is correct.
